// File: rtl/nand_tree_pkg.sv
// Shared types and helpers for the pipelined reduction-gate tree.
package nand_tree_pkg;

   localparam int STATS_W = 16;

   typedef enum logic [2:0] {
      MODE_AND  = 3'd0,
      MODE_NAND = 3'd1,
      MODE_OR   = 3'd2,
      MODE_NOR  = 3'd3,
      MODE_XOR  = 3'd4,
      MODE_XNOR = 3'd5,
      MODE_RSV6 = 3'd6,
      MODE_RSV7 = 3'd7
   } gate_mode_t;

   typedef enum logic [1:0] {
      FAM_AND = 2'd0,
      FAM_OR  = 2'd1,
      FAM_XOR = 2'd2
   } gate_family_t;

   // Ceiling log2; 0 for n <= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v * 2) r++;
      return r;
   endfunction

   // Associative operator used inside the tree; reserved codes behave as NAND.
   function automatic gate_family_t family(input gate_mode_t m);
      case (m)
         MODE_OR, MODE_NOR:   return FAM_OR;
         MODE_XOR, MODE_XNOR: return FAM_XOR;
         default:             return FAM_AND;
      endcase
   endfunction

   // Neutral element of the tree operator: pads unused leaves and masked inputs.
   function automatic logic identity(input gate_mode_t m);
      return (family(m) == FAM_AND);
   endfunction

   function automatic logic is_inverting(input gate_mode_t m);
      case (m)
         MODE_AND, MODE_OR, MODE_XOR: return 1'b0;
         default:                     return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/nand_tree_stage.sv
// One pipeline stage of the reduction tree: collapses IN_W leaves per channel
// down to OUT_W nodes and registers them with a valid bit that holds on stall.
module nand_tree_stage
   import nand_tree_pkg::*;
#(
   parameter int CH    = 1,
   parameter int IN_W  = 4,
   parameter int OUT_W = 1,
   parameter bit LAST  = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hold,
   input  logic               vld_in,
   input  logic [2:0]         mode_in,
   input  logic [CH*IN_W-1:0] din,
   output logic               vld_out,
   output logic [CH*OUT_W-1:0] dout
);

   localparam int GRP = IN_W / OUT_W;

   gate_mode_t          m;
   logic [GRP-1:0]      grp;
   logic [CH*OUT_W-1:0] red;

   assign m = gate_mode_t'(mode_in);

   // Reduce each group of adjacent leaves to one node; the final stage applies the inversion.
   always_comb begin
      red = '0;
      grp = '0;
      for (int c = 0; c < CH; c++) begin
         for (int o = 0; o < OUT_W; o++) begin
            grp = din[c*IN_W + o*GRP +: GRP];
            case (family(m))
               FAM_OR:  red[c*OUT_W + o] = |grp;
               FAM_XOR: red[c*OUT_W + o] = ^grp;
               default: red[c*OUT_W + o] = &grp;
            endcase
            if (LAST && is_inverting(m)) red[c*OUT_W + o] = ~red[c*OUT_W + o];
         end
      end
   end

   // Stage register bank; frozen while the pipeline is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_out <= 1'b0;
         dout    <= '0;
      end else if (!hold) begin
         vld_out <= vld_in;
         dout    <= red;
      end
   end

endmodule

// File: rtl/nand_tree_pipe.sv
// Pipelined, multi-channel N-input reduction gate (AND/NAND/OR/NOR/XOR/XNOR)
// with per-input mask and a valid/ready stream interface under global stall.
// Optional feature macro: NAND_TREE_STATS_EN adds stat_clr/stat_ones, a
// saturating count of accepted results whose channel-0 bit is 1.
module nand_tree_pipe
   import nand_tree_pkg::*;
#(
   parameter int N_IN       = 3,
   parameter int CH         = 1,
   parameter int STAGE_LVLS = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CH*N_IN-1:0] in_data,
   input  logic [N_IN-1:0]    in_mask,
   input  logic [2:0]         mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CH-1:0]      out_data
`ifdef NAND_TREE_STATS_EN
   ,
   input  logic               stat_clr,
   output logic [STATS_W-1:0] stat_ones
`endif
);

   localparam int D  = (clog2(N_IN) > 1) ? clog2(N_IN) : 1;
   localparam int S  = (D + STAGE_LVLS - 1) / STAGE_LVLS;
   localparam int LW = 1 << D;

   // Bit offset of tree-stage k's input segment inside the data chain.
   function automatic int seg_off(input int k);
      int o;
      o = 0;
      for (int j = 0; j < k; j++) o += CH * (1 << (D - j*STAGE_LVLS));
      return o;
   endfunction

   localparam int TOT = seg_off(S);

   logic               stall;
   logic               vld_p0;
   logic [CH*N_IN-1:0] data_p0;
   logic [N_IN-1:0]    mask_p0;
   logic [2:0]         mode_p0;
   logic               ident;
   logic [CH*LW-1:0]   leaves;

   wire  [TOT-1:0]     dchain;
   wire  [S:0]         vld_chain;
   wire  [3*S-1:0]     mode_chain;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !rst && !stall;
   assign ident    = identity(gate_mode_t'(mode_p0));

   // Input register: capture sample, mask and mode on handshake; hold during stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0  <= 1'b0;
         data_p0 <= '0;
         mask_p0 <= '0;
         mode_p0 <= '0;
      end else if (!stall) begin
         vld_p0 <= in_valid;
         if (in_valid) begin
            data_p0 <= in_data;
            mask_p0 <= in_mask;
            mode_p0 <= mode;
         end
      end
   end

   // Build the padded leaf row: masked and padding leaves take the operator identity.
   always_comb begin
      leaves = '0;
      for (int c = 0; c < CH; c++) begin
         for (int i = 0; i < LW; i++) leaves[c*LW + i] = ident;
         for (int i = 0; i < N_IN; i++)
            if (!mask_p0[i]) leaves[c*LW + i] = data_p0[c*N_IN + i];
      end
   end

   assign dchain[0 +: CH*LW]  = leaves;
   assign vld_chain[0]        = vld_p0;
   assign mode_chain[0 +: 3]  = mode_p0;
   assign out_valid           = vld_chain[S];

   for (genvar k = 0; k < S; k++) begin : g_stg
      localparam int IW   = 1 << (D - k*STAGE_LVLS);
      localparam int OL   = (D - (k+1)*STAGE_LVLS > 0) ? D - (k+1)*STAGE_LVLS : 0;
      localparam int OW   = 1 << OL;
      localparam bit LAST = (k == S-1);

      logic [CH*OW-1:0] dout;

      nand_tree_stage #(
         .CH   (CH),
         .IN_W (IW),
         .OUT_W(OW),
         .LAST (LAST)
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .hold   (stall),
         .vld_in (vld_chain[k]),
         .mode_in(mode_chain[3*k +: 3]),
         .din    (dchain[seg_off(k) +: CH*IW]),
         .vld_out(vld_chain[k+1]),
         .dout   (dout)
      );

      if (LAST) begin : g_out
         assign out_data = dout;
      end else begin : g_mid
         logic [2:0] mode_q;

         // Carry each sample's mode alongside its partial results.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)         mode_q <= '0;
            else if (!stall) mode_q <= mode_chain[3*k +: 3];
         end

         assign dchain[seg_off(k+1) +: CH*OW] = dout;
         assign mode_chain[3*(k+1) +: 3]      = mode_q;
      end
   end

`ifdef NAND_TREE_STATS_EN
   // Saturating count of accepted results with channel-0 bit set; clear beats increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stat_ones <= '0;
      else if (stat_clr)
         stat_ones <= '0;
      else if (out_valid && out_ready && out_data[0] && (stat_ones != {STATS_W{1'b1}}))
         stat_ones <= stat_ones + 1'b1;
   end
`endif

endmodule

// File: tb/tb_nand_tree_pipe.sv
// Randomised, scoreboard-based bench for nand_tree_pipe (default build and
// an 8-input, 2-channel, one-level-per-stage variant).
module tb_nand_tree_pipe;

   localparam int L  = 2;   // N_IN=3, STAGE_LVLS=2
   localparam int L8 = 4;   // N_IN=8, STAGE_LVLS=1

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  in_data, in_mask, mode;
   logic [0:0]  out_data;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [15:0] in_data8;
   logic [7:0]  in_mask8;
   logic [2:0]  mode8;
   logic [1:0]  out_data8;

`ifdef NAND_TREE_STATS_EN
   logic        stat_clr, stat_clr8;
   logic [15:0] stat_ones, stat_ones8;
   int          ones_model;
`endif

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   bit   chk_lat;
   bit   rnd_done;
   logic exp_q[$];
   int   cyc_q[$];
   bit   prev_stall;
   logic [0:0] prev_data;
   logic exp_b;
   int   t0;

   nand_tree_pipe u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef NAND_TREE_STATS_EN
      , .stat_clr(stat_clr), .stat_ones(stat_ones)
`endif
   );

   nand_tree_pipe #(.N_IN(8), .CH(2), .STAGE_LVLS(1)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_mask(in_mask8), .mode(mode8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8)
`ifdef NAND_TREE_STATS_EN
      , .stat_clr(stat_clr8), .stat_ones(stat_ones8)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: reduce the unmasked bits by counting ones.
   function automatic logic ref_bit(input logic [7:0] d, input logic [7:0] m, input int n,
                                    input logic [2:0] md);
      int ones, cnt;
      ones = 0; cnt = 0;
      for (int i = 0; i < n; i++)
         if (!m[i]) begin cnt++; ones += int'(d[i]); end
      case (md)
         3'd0:    return ones == cnt;
         3'd2:    return ones > 0;
         3'd3:    return ones == 0;
         3'd4:    return ones % 2 == 1;
         3'd5:    return ones % 2 == 0;
         default: return ones != cnt;
      endcase
   endfunction

   // Scoreboard / protocol monitor for the default instance.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
`ifdef NAND_TREE_STATS_EN
         ones_model = 0;
`endif
      end else begin
         if (prev_stall) check("hold_data", out_data, prev_data);
         if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_bit({5'b0, in_data}, {5'b0, in_mask}, 3, mode));
            cyc_q.push_back(cyc);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
            else begin
               exp_b = exp_q.pop_front();
               t0    = cyc_q.pop_front();
               check("out_data", out_data, exp_b);
               if (chk_lat) check("latency", cyc - t0, L);
            end
         end
`ifdef NAND_TREE_STATS_EN
         if (stat_clr) ones_model = 0;
         else if (out_valid && out_ready && out_data[0] && ones_model < 65535) ones_model++;
`endif
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] d, input logic [2:0] m, input logic [2:0] md);
      bit acc;
      acc = 1'b0;
      in_data = d; in_mask = m; mode = md; in_valid = 1'b1;
      for (int t = 0; t < 100 && !acc; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) check("send_timeout", acc, 1);
      in_valid = 1'b0;
   endtask

   // Two back-to-back samples into the 8-input instance; checks both results and latency.
   task automatic pair8(input logic [15:0] d0, input logic [15:0] d1, input logic [7:0] m0,
                        input logic [7:0] m1, input logic [2:0] md0, input logic [2:0] md1);
      logic [1:0] e0, e1;
      int  n;
      bit  seen;
      e0 = {ref_bit(d0[15:8], m0, 8, md0), ref_bit(d0[7:0], m0, 8, md0)};
      e1 = {ref_bit(d1[15:8], m1, 8, md1), ref_bit(d1[7:0], m1, 8, md1)};
      @(negedge clk);
      check("in_ready8", in_ready8, 1);
      in_data8 = d0; in_mask8 = m0; mode8 = md0; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_data8 = d1; in_mask8 = m1; mode8 = md1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      n = 2; seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         if (out_valid8) seen = 1'b1;
         else begin @(posedge clk); #1; n++; end
      end
      check("seen8", seen, 1);
      check("lat8", n, L8);
      check("data8_a", out_data8, e0);
      @(negedge clk);
      check("valid8_b", out_valid8, 1);
      check("data8_b", out_data8, e1);
      idle(3);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; chk_lat = 1'b0; rnd_done = 1'b0;
      in_valid = 1'b0; in_data = '0; in_mask = '0; mode = '0; out_ready = 1'b1;
      in_valid8 = 1'b0; in_data8 = '0; in_mask8 = '0; mode8 = '0; out_ready8 = 1'b1;
`ifdef NAND_TREE_STATS_EN
      stat_clr = 1'b0; stat_clr8 = 1'b0;
`endif
      idle(2);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid8", out_valid8, 0);
      check("rst_out_data8", out_data8, 0);
      rst = 1'b0;
      idle(2);

      // Back-to-back NAND samples, nominal latency.
      chk_lat = 1'b1;
      send(3'b111, 3'b000, 3'd1);
      send(3'b011, 3'b000, 3'd1);
      idle(4);

      // Masking, including all-masked results.
      send(3'b011, 3'b100, 3'd0);
      send(3'b101, 3'b111, 3'd1);
      send(3'b000, 3'b111, 3'd3);
      send(3'b111, 3'b111, 3'd4);
      send(3'b010, 3'b111, 3'd5);
      send(3'b110, 3'b001, 3'd7);
      idle(4);

      // Eight-sample stream with a five-cycle downstream stall.
      chk_lat = 1'b0;
      fork
         for (int i = 0; i < 8; i++)
            send(3'($urandom), 3'($urandom), 3'($urandom_range(0, 7)));
         begin
            idle(3);
            out_ready = 1'b0;
            idle(5);
            out_ready = 1'b1;
         end
      join
      idle(6);
      check("stall_drained", exp_q.size(), 0);

      // Random traffic with random backpressure.
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) idle(1);
               send(3'($urandom), 3'($urandom), 3'($urandom_range(0, 7)));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               out_ready = ($urandom_range(0, 9) < 7);
               idle(1);
            end
            out_ready = 1'b1;
         end
      join
      idle(6);
      check("rand_drained", exp_q.size(), 0);

      // Wide, fully pipelined instance: XOR then XNOR on the same data.
      pair8({8'hFF, 8'h01}, {8'hFF, 8'h01}, 8'h00, 8'h00, 3'd4, 3'd5);
      for (int i = 0; i < 6; i++)
         pair8(16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

`ifdef NAND_TREE_STATS_EN
      stat_clr = 1'b1; idle(1); stat_clr = 1'b0;
      for (int i = 0; i < 10; i++) send((i < 4) ? 3'b111 : 3'b010, 3'b000, 3'd1);
      idle(4);
      check("stat_six", stat_ones, 6);
      send(3'b000, 3'b000, 3'd1);
      idle(1);
      stat_clr = 1'b1; idle(1); stat_clr = 1'b0;
      idle(2);
      check("stat_clr_hit", stat_ones, 0);
      in_data = 3'b000; in_mask = 3'b000; mode = 3'd1; in_valid = 1'b1;
      idle(65540);
      in_valid = 1'b0;
      idle(4);
      check("stat_sat", stat_ones, 16'hFFFF);
      check("stat_model", stat_ones, ones_model);
`endif

      // Asynchronous reset with two samples in flight.
      chk_lat = 1'b0;
      send(3'b111, 3'b000, 3'd4);
      send(3'b010, 3'b000, 3'd4);
      #1;
      rst = 1'b1;
      #1;
      check("rst_async_valid", out_valid, 0);
      check("rst_async_ready", in_ready, 0);
      exp_q.delete();
      cyc_q.delete();
      idle(1);
      rst = 1'b0;
`ifdef NAND_TREE_STATS_EN
      check("stat_rst", stat_ones, 0);
`endif
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("no_stale", out_valid, 0);
      end
      @(posedge clk); #1;
      chk_lat = 1'b1;
      send(3'b101, 3'b000, 3'd2);
      idle(4);
      check("post_rst_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
